// File: rtl/hwpe_ctrl_offloader.sv
// Offloads one job to an HWPE over a peripheral master port: acquire, parameter writes, trigger.
// Define HWPE_OFFLOAD_POLL_EN to also poll the status register until the job has finished.
module hwpe_ctrl_offloader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned N_IO_REGS      = 2,
   parameter int unsigned IO_BASE_REG    = 16,
   parameter int unsigned BACKOFF_CYCLES = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    job_valid_i,
   output logic                    job_ready_o,
   input  logic [N_IO_REGS*32-1:0] job_params_i,
   output logic [7:0]              job_id_o,
   output logic                    job_done_o,
   output logic                    busy_o,
   output logic [7:0]              retries_o,
   output logic [3:0]              dbg_state_o,
   output logic                    req_o,
   input  logic                    gnt_i,
   output logic [31:0]             add_o,
   output logic                    wen_o,
   output logic [3:0]              be_o,
   output logic [31:0]             data_o,
   input  logic                    r_valid_i,
   input  logic [31:0]             r_data_i
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ACQ_REQ   = 4'd1,
      ACQ_WAIT  = 4'd2,
      BACKOFF   = 4'd3,
      WR_PARAM  = 4'd4,
      TRIG      = 4'd5,
      DONE      = 4'd6,
      POLL_REQ  = 4'd7,
      POLL_WAIT = 4'd8
   } state_t;

   localparam logic [31:0] REG_TRIGGER = 32'd0;
   localparam logic [31:0] REG_ACQUIRE = 32'd1;
   localparam logic [7:0]  BACKOFF_INI = 8'(BACKOFF_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [4:0]              idx_q, idx_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [N_IO_REGS*32-1:0] params_q, params_d;
   logic [7:0]              job_id_q, job_id_d;
   logic [7:0]              retries_q, retries_d;
`ifdef HWPE_OFFLOAD_POLL_EN
   localparam logic [31:0] REG_STATUS = 32'd3;
   logic                    pwait_q, pwait_d;
`endif

   function automatic logic [31:0] reg_addr(input logic [31:0] idx);
      return BASE_ADDR + (idx << 2);
   endfunction

   assign job_ready_o = (state_q == IDLE) && rst_ni;
   assign busy_o      = (state_q != IDLE);
   assign job_id_o    = job_id_q;
   assign retries_o   = retries_q;
   assign dbg_state_o = state_q;

   // Handshake: req_o and the bus fields depend only on registered state, so they stay
   // stable until the cycle with gnt_i=1; that cycle completes the transfer.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      params_d   = params_q;
      job_id_d   = job_id_q;
      retries_d  = retries_q;
`ifdef HWPE_OFFLOAD_POLL_EN
      pwait_d    = pwait_q;
`endif
      req_o      = 1'b0;
      wen_o      = 1'b1;
      add_o      = 32'd0;
      be_o       = 4'h0;
      data_o     = 32'd0;
      job_done_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (job_valid_i && job_ready_o) begin
               params_d  = job_params_i;
               retries_d = 8'd0;
               state_d   = ACQ_REQ;
            end
         end
         ACQ_REQ: begin
            req_o = 1'b1;
            be_o  = 4'hF;
            add_o = reg_addr(REG_ACQUIRE);
            if (gnt_i) state_d = ACQ_WAIT;
         end
         ACQ_WAIT: begin
            if (r_valid_i) begin
               if (r_data_i == 32'hFFFF_FFFE || r_data_i == 32'hFFFF_FFFF) begin
                  retries_d = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;
                  cnt_d     = BACKOFF_INI;
                  state_d   = BACKOFF;
               end else begin
                  job_id_d = r_data_i[7:0];
                  idx_d    = 5'd0;
                  state_d  = WR_PARAM;
               end
            end
         end
         BACKOFF: begin
            if (cnt_q == 8'd0) state_d = ACQ_REQ;
            else               cnt_d   = cnt_q - 8'd1;
         end
         WR_PARAM: begin
            req_o  = 1'b1;
            wen_o  = 1'b0;
            be_o   = 4'hF;
            add_o  = reg_addr(32'(IO_BASE_REG) + 32'(idx_q));
            data_o = params_q[32*int'(idx_q) +: 32];
            if (gnt_i) begin
               if (idx_q == 5'(N_IO_REGS - 1)) state_d = TRIG;
               else                            idx_d   = idx_q + 5'd1;
            end
         end
         TRIG: begin
            req_o = 1'b1;
            wen_o = 1'b0;
            be_o  = 4'hF;
            add_o = reg_addr(REG_TRIGGER);
`ifdef HWPE_OFFLOAD_POLL_EN
            if (gnt_i) state_d = POLL_REQ;
`else
            if (gnt_i) state_d = DONE;
`endif
         end
`ifdef HWPE_OFFLOAD_POLL_EN
         POLL_REQ: begin
            req_o = 1'b1;
            be_o  = 4'hF;
            add_o = reg_addr(REG_STATUS);
            if (gnt_i) begin
               pwait_d = 1'b0;
               state_d = POLL_WAIT;
            end
         end
         POLL_WAIT: begin
            // After a non-zero status, the same state counts out the backoff before re-polling.
            if (pwait_q) begin
               if (cnt_q == 8'd0) begin
                  pwait_d = 1'b0;
                  state_d = POLL_REQ;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end else if (r_valid_i) begin
               if (r_data_i == 32'd0) begin
                  state_d = DONE;
               end else begin
                  pwait_d = 1'b1;
                  cnt_d   = BACKOFF_INI;
               end
            end
         end
`endif
         DONE: begin
            job_done_o = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d   = IDLE;
         idx_d     = 5'd0;
         cnt_d     = 8'd0;
         job_id_d  = 8'd0;
         retries_d = 8'd0;
`ifdef HWPE_OFFLOAD_POLL_EN
         pwait_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         idx_q     <= 5'd0;
         cnt_q     <= 8'd0;
         params_q  <= '0;
         job_id_q  <= 8'd0;
         retries_q <= 8'd0;
`ifdef HWPE_OFFLOAD_POLL_EN
         pwait_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         params_q  <= params_d;
         job_id_q  <= job_id_d;
         retries_q <= retries_d;
`ifdef HWPE_OFFLOAD_POLL_EN
         pwait_q   <= pwait_d;
`endif
      end
   end

endmodule

// File: tb/tb_hwpe_ctrl_offloader.sv
// Directed bench for hwpe_ctrl_offloader: a small peripheral slave answers acquire and status
// reads from queues and logs every granted write for comparison against expected writes.
module tb_hwpe_ctrl_offloader;

   localparam logic [31:0] BASE    = 32'h1A10_0000;
   localparam int          N       = 2;
   localparam int          BO      = 4;
`ifdef HWPE_OFFLOAD_POLL_EN
   localparam int          DONE_LAT = N + 6;
`else
   localparam int          DONE_LAT = N + 4;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clear = 1'b0;
   logic            job_valid = 1'b0;
   logic            job_ready;
   logic [N*32-1:0] job_params = '0;
   logic [7:0]      job_id;
   logic            job_done;
   logic            busy;
   logic [7:0]      retries;
   logic [3:0]      dbg_state;
   logic            req;
   logic            gnt = 1'b1;
   logic [31:0]     add;
   logic            wen;
   logic [3:0]      be;
   logic [31:0]     data;
   logic            r_valid = 1'b0;
   logic [31:0]     r_data = '0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int hs_cnt = 0;
   int hs_cyc = 0;
   int stat_cnt = 0;
   int stat_resp_cyc = 0;

   logic [31:0] acq_resp_q[$];
   logic [31:0] stat_resp_q[$];
   int          acq_cyc_q[$];
   logic [63:0] act_q[$];
   logic [63:0] exp_q[$];

   hwpe_ctrl_offloader #(
      .BASE_ADDR(BASE), .N_IO_REGS(N), .IO_BASE_REG(16), .BACKOFF_CYCLES(BO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .job_valid_i(job_valid), .job_ready_o(job_ready), .job_params_i(job_params),
      .job_id_o(job_id), .job_done_o(job_done), .busy_o(busy), .retries_o(retries),
      .dbg_state_o(dbg_state),
      .req_o(req), .gnt_i(gnt), .add_o(add), .wen_o(wen), .be_o(be), .data_o(data),
      .r_valid_i(r_valid), .r_data_i(r_data)
   );

   // clock / reset
   always #5 clk = ~clk;

   // slave model and monitors
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      r_valid <= 1'b0;
      if (rst_n && req && gnt && wen) begin
         r_valid <= 1'b1;
         if (add == BASE + 32'h4) begin
            acq_cyc_q.push_back(cyc);
            if (acq_resp_q.size() > 0) r_data <= acq_resp_q.pop_front();
            else                       r_data <= 32'd5;
         end else begin
            stat_cnt      <= stat_cnt + 1;
            stat_resp_cyc <= cyc + 1;
            if (stat_resp_q.size() > 0) r_data <= stat_resp_q.pop_front();
            else                        r_data <= 32'd0;
         end
      end
      if (rst_n && req && gnt && !wen) act_q.push_back({add, data});
      if (job_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (job_valid && job_ready) begin
         hs_cnt <= hs_cnt + 1;
         hs_cyc <= cyc;
      end
   end

   // driver tasks
   task automatic send_job(input logic [N*32-1:0] p);
      int start;
      int k;
      start = hs_cnt;
      @(negedge clk);
      job_params = p;
      job_valid  = 1'b1;
      k = 0;
      while (hs_cnt == start && k < 50) begin
         @(negedge clk);
         k++;
      end
      job_valid = 1'b0;
      n_cmp++;
      if (hs_cnt == start) begin
         n_err++;
         $display("FAIL handshake_timeout: no handshake after %0d cycles, required 1", k);
      end
   endtask

   task automatic wait_done(input int budget);
      int start;
      int k;
      start = done_cnt;
      k = 0;
      while (done_cnt == start && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (done_cnt == start) begin
         n_err++;
         $display("FAIL done_timeout: no job_done after %0d cycles", budget);
      end
   endtask

   task automatic check_writes(input string name);
      n_cmp++;
      if (act_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL %s_count: got %0d writes, required %0d", name, act_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL %s_write%0d: got addr/data %h, required %h", name, i, act_q[i], exp_q[i]);
            end
         end
      end
   endtask

   // scenarios
   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({req, wen, add, be, data} !== {1'b0, 1'b1, 32'd0, 4'h0, 32'd0}) begin
         n_err++;
         $display("FAIL reset_bus: got req=%b wen=%b add=%h be=%h data=%h, required 0 1 0 0 0",
                  req, wen, add, be, data);
      end
      n_cmp++;
      if ({job_ready, job_done, busy, job_id, retries, dbg_state} !== 21'd0) begin
         n_err++;
         $display("FAIL reset_ctrl: got ready=%b done=%b busy=%b id=%h retries=%h state=%h, required all 0",
                  job_ready, job_done, busy, job_id, retries, dbg_state);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({job_ready, busy} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_idle: got ready=%b busy=%b, required 1 0", job_ready, busy);
      end
   endtask

   task automatic test_basic();
      act_q.delete();
      exp_q.delete();
      acq_resp_q.push_back(32'd5);
      exp_q.push_back({BASE + 32'h40, 32'hA});
      exp_q.push_back({BASE + 32'h44, 32'hB});
      exp_q.push_back({BASE, 32'h0});
      send_job({32'hB, 32'hA});
      wait_done(40);
      check_writes("basic");
      n_cmp++;
      if (job_id !== 8'd5) begin
         n_err++;
         $display("FAIL basic_job_id: got %0d, required 5", job_id);
      end
      n_cmp++;
      if (done_cyc - hs_cyc != DONE_LAT) begin
         n_err++;
         $display("FAIL basic_latency: got %0d cycles, required %0d", done_cyc - hs_cyc, DONE_LAT);
      end
      n_cmp++;
      if ({busy, retries} !== 9'd0) begin
         n_err++;
         $display("FAIL basic_after: got busy=%b retries=%0d, required 0 0", busy, retries);
      end
   endtask

   task automatic test_retry();
      acq_cyc_q.delete();
      acq_resp_q.push_back(32'hFFFF_FFFF);
      acq_resp_q.push_back(32'hFFFF_FFFF);
      acq_resp_q.push_back(32'd3);
      send_job({32'h22, 32'h11});
      wait_done(80);
      n_cmp++;
      if (retries !== 8'd2) begin
         n_err++;
         $display("FAIL retry_count: got %0d, required 2", retries);
      end
      n_cmp++;
      if (job_id !== 8'd3) begin
         n_err++;
         $display("FAIL retry_job_id: got %0d, required 3", job_id);
      end
      n_cmp++;
      if (acq_cyc_q.size() != 3) begin
         n_err++;
         $display("FAIL retry_acquires: got %0d acquire reads, required 3", acq_cyc_q.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (acq_cyc_q[i] - acq_cyc_q[i-1] != BO + 2) begin
               n_err++;
               $display("FAIL retry_spacing%0d: got %0d cycles between acquires, required %0d",
                        i, acq_cyc_q[i] - acq_cyc_q[i-1], BO + 2);
            end
         end
      end
   endtask

   task automatic test_grant_stall();
      int k;
      act_q.delete();
      exp_q.delete();
      acq_resp_q.push_back(32'd6);
      exp_q.push_back({BASE + 32'h40, 32'h1234_5678});
      exp_q.push_back({BASE + 32'h44, 32'hCAFE_F00D});
      exp_q.push_back({BASE, 32'h0});
      send_job({32'hCAFE_F00D, 32'h1234_5678});
      k = 0;
      while (!(req && !wen && add == BASE + 32'h44) && k < 20) begin
         @(negedge clk);
         k++;
      end
      gnt = 1'b0;
      for (int i = 0; i < 7; i++) begin
         n_cmp++;
         if ({req, wen, add, be, data} !== {1'b1, 1'b0, BASE + 32'h44, 4'hF, 32'hCAFE_F00D}) begin
            n_err++;
            $display("FAIL stall_stable%0d: got req=%b wen=%b add=%h be=%h data=%h, required 1 0 %h f cafef00d",
                     i, req, wen, add, be, data, BASE + 32'h44);
         end
         @(negedge clk);
      end
      gnt = 1'b1;
      wait_done(40);
      check_writes("stall");
   endtask

   task automatic test_clear();
      int k;
      act_q.delete();
      exp_q.delete();
      acq_resp_q.push_back(32'd9);
      exp_q.push_back({BASE + 32'h40, 32'h0000_0C0C});
      send_job({32'h0000_0D0D, 32'h0000_0C0C});
      k = 0;
      while (!(req && !wen && add == BASE + 32'h40) && k < 20) begin
         @(negedge clk);
         k++;
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_cmp++;
      if ({req, busy, job_ready, job_id, retries, dbg_state} !== {3'b001, 8'd0, 8'd0, 4'd0}) begin
         n_err++;
         $display("FAIL clear_idle: got req=%b busy=%b ready=%b id=%0d retries=%0d state=%0d, required 0 0 1 0 0 0",
                  req, busy, job_ready, job_id, retries, dbg_state);
      end
      repeat (10) @(negedge clk);
      check_writes("clear");
      act_q.delete();
      exp_q.delete();
      acq_resp_q.push_back(32'd7);
      exp_q.push_back({BASE + 32'h40, 32'h0000_00C1});
      exp_q.push_back({BASE + 32'h44, 32'h0000_00D1});
      exp_q.push_back({BASE, 32'h0});
      send_job({32'h0000_00D1, 32'h0000_00C1});
      wait_done(40);
      check_writes("after_clear");
      n_cmp++;
      if (job_id !== 8'd7) begin
         n_err++;
         $display("FAIL after_clear_job_id: got %0d, required 7", job_id);
      end
   endtask

   task automatic test_saturation();
      int k;
      acq_cyc_q.delete();
      for (int i = 0; i < 300; i++)
         acq_resp_q.push_back((i % 2 == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      acq_resp_q.push_back(32'd2);
      send_job({32'h44, 32'h33});
      k = 0;
      while (acq_cyc_q.size() < 280 && k < 2500) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (retries !== 8'd255) begin
         n_err++;
         $display("FAIL sat_mid: got %0d retries after 280 acquires, required 255", retries);
      end
      wait_done(1000);
      n_cmp++;
      if (retries !== 8'd255) begin
         n_err++;
         $display("FAIL sat_final: got %0d retries, required 255", retries);
      end
      n_cmp++;
      if (acq_cyc_q.size() != 301) begin
         n_err++;
         $display("FAIL sat_acquires: got %0d acquire reads, required 301", acq_cyc_q.size());
      end
      n_cmp++;
      if (job_id !== 8'd2) begin
         n_err++;
         $display("FAIL sat_job_id: got %0d, required 2", job_id);
      end
   endtask

`ifdef HWPE_OFFLOAD_POLL_EN
   task automatic test_poll();
      int start;
      start = stat_cnt;
      acq_resp_q.push_back(32'd4);
      stat_resp_q.push_back(32'd1);
      stat_resp_q.push_back(32'd1);
      stat_resp_q.push_back(32'd0);
      send_job({32'h66, 32'h55});
      wait_done(100);
      n_cmp++;
      if (stat_cnt - start != 3) begin
         n_err++;
         $display("FAIL poll_reads: got %0d status reads, required 3", stat_cnt - start);
      end
      n_cmp++;
      if (done_cyc - stat_resp_cyc != 1) begin
         n_err++;
         $display("FAIL poll_done: got done %0d cycles after last status, required 1",
                  done_cyc - stat_resp_cyc);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_retry();
      test_grant_stall();
      test_clear();
      test_saturation();
`ifdef HWPE_OFFLOAD_POLL_EN
      test_poll();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
